// File: rtl/axil_rr_master.sv
// Two-requester round-robin front end for a single AXI-Lite master port.
// One transaction in flight; per-phase stall counter flags slow slaves without aborting.
module axil_rr_master #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 8,
    parameter int MAX_WAIT         = 5
) (
    input  logic                          AXI_ACLK,
    input  logic                          AXI_ARESET,
    input  logic [1:0]                    req_valid,
    input  logic [1:0]                    req_write,
    input  logic [2*C_AXI_ADDR_WIDTH-1:0] req_addr,
    input  logic [2*C_AXI_DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]                    req_ready,
    output logic [1:0]                    rsp_valid,
    output logic [C_AXI_DATA_WIDTH-1:0]   rsp_data,
    output logic [1:0]                    rsp_resp,
    output logic                          rsp_timeout,
    output logic [C_AXI_ADDR_WIDTH-1:0]   AXI_AWADDR,
    output logic                          AXI_AWVALID,
    input  logic                          AXI_AWREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]   AXI_WDATA,
    output logic                          AXI_WVALID,
    input  logic                          AXI_WREADY,
    input  logic [1:0]                    AXI_BRESP,
    input  logic                          AXI_BVALID,
    output logic                          AXI_BREADY,
    output logic [C_AXI_ADDR_WIDTH-1:0]   AXI_ARADDR,
    output logic                          AXI_ARVALID,
    input  logic                          AXI_ARREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   AXI_RDATA,
    input  logic                          AXI_RVALID,
    output logic                          AXI_RREADY
);

    localparam int AW = C_AXI_ADDR_WIDTH;
    localparam int DW = C_AXI_DATA_WIDTH;
    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] L_MAX  = CW'(MAX_WAIT);
    localparam logic [CW-1:0] L_LAST = L_MAX - CW'(1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_REQ  = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_REQ  = 3'd3;
    localparam logic [2:0] S_RD_DATA = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic          r_last_grant;
    logic          r_grant;
    logic          r_awvalid;
    logic          r_wvalid;
    logic          r_arvalid;
    logic [CW-1:0] r_wait_cnt;
    logic          r_timeout;
    logic [DW-1:0] r_rsp_data;
    logic [1:0]    r_rsp_resp;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;

    logic w_grant;
    logic w_accept;
    logic w_sel_write;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_ar_hs;
    logic w_b_hs;
    logic w_r_hs;
    logic w_any_hs;
    logic w_wait_state;
    logic w_stall;
    logic w_aw_ok;
    logic w_w_ok;

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        w_grant = 1'b0;
        if (req_valid == 2'b11) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = req_valid[1];
        end
    end

    assign w_accept    = (r_state == S_IDLE) && (|req_valid) && !AXI_ARESET;
    assign w_sel_write = req_write[w_grant];

    assign w_aw_hs  = r_awvalid && AXI_AWREADY;
    assign w_w_hs   = r_wvalid && AXI_WREADY;
    assign w_ar_hs  = r_arvalid && AXI_ARREADY;
    assign w_b_hs   = (r_state == S_WR_RESP) && AXI_BVALID;
    assign w_r_hs   = (r_state == S_RD_DATA) && AXI_RVALID;
    assign w_any_hs = w_aw_hs || w_w_hs || w_ar_hs || w_b_hs || w_r_hs;

    assign w_wait_state = (r_state == S_WR_REQ) || (r_state == S_WR_RESP) ||
                          (r_state == S_RD_REQ) || (r_state == S_RD_DATA);
    assign w_stall      = w_wait_state && !w_any_hs;

    // A channel is finished once its valid is gone or it handshakes this cycle.
    assign w_aw_ok = !r_awvalid || AXI_AWREADY;
    assign w_w_ok  = !r_wvalid || AXI_WREADY;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_state_nxt = w_sel_write ? S_WR_REQ : S_RD_REQ;
            S_WR_REQ:  if (w_aw_ok && w_w_ok) w_state_nxt = S_WR_RESP;
            S_WR_RESP: if (AXI_BVALID) w_state_nxt = S_DONE;
            S_RD_REQ:  if (AXI_ARREADY) w_state_nxt = S_RD_DATA;
            S_RD_DATA: if (AXI_RVALID) w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_wait_cnt   <= '0;
            r_timeout    <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_resp   <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_grant      <= w_grant;
                        r_last_grant <= w_grant;
                        r_timeout    <= 1'b0;
                        r_awvalid    <= w_sel_write;
                        r_wvalid     <= w_sel_write;
                        r_arvalid    <= !w_sel_write;
                    end
                end
                S_WR_REQ: begin
                    if (w_aw_hs) r_awvalid <= 1'b0;
                    if (w_w_hs)  r_wvalid  <= 1'b0;
                end
                S_RD_REQ: begin
                    if (w_ar_hs) r_arvalid <= 1'b0;
                end
                S_WR_RESP: begin
                    if (AXI_BVALID) begin
                        r_rsp_data <= '0;
                        r_rsp_resp <= AXI_BRESP;
                    end
                end
                S_RD_DATA: begin
                    if (AXI_RVALID) begin
                        r_rsp_data <= AXI_RDATA;
                        r_rsp_resp <= 2'b00;
                    end
                end
                default: ;
            endcase

            // Counts consecutive stalled cycles within a phase; saturates, never aborts.
            if (!w_stall) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != L_MAX) begin
                r_wait_cnt <= r_wait_cnt + CW'(1);
            end
            if (w_stall && (r_wait_cnt >= L_LAST)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (w_accept) begin
            r_addr  <= w_grant ? req_addr[2*AW-1:AW]  : req_addr[AW-1:0];
            r_wdata <= w_grant ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
        end
    end

    assign req_ready   = w_accept ? {w_grant, !w_grant} : 2'b00;
    assign rsp_valid   = ((r_state == S_DONE) && !AXI_ARESET) ? {r_grant, !r_grant} : 2'b00;
    assign rsp_data    = r_rsp_data;
    assign rsp_resp    = r_rsp_resp;
    assign rsp_timeout = r_timeout;

    assign AXI_AWADDR  = r_addr;
    assign AXI_AWVALID = r_awvalid;
    assign AXI_WDATA   = r_wdata;
    assign AXI_WVALID  = r_wvalid;
    assign AXI_BREADY  = (r_state == S_WR_RESP) && !AXI_ARESET;
    assign AXI_ARADDR  = r_addr;
    assign AXI_ARVALID = r_arvalid;
    assign AXI_RREADY  = (r_state == S_RD_DATA) && !AXI_ARESET;

endmodule

// File: tb/tb_axil_rr_master.sv
// Bench for axil_rr_master: randomized requesters, scripted-delay AXI-Lite slave with
// protocol checks, and a scoreboard fed by a transaction-level model.
module tb_axil_rr_master;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int MAX_WAIT = 5;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic [1:0]    bresp;
        int            d_aw;
        int            d_w;
        int            d_b;
        int            d_ar;
        int            d_r;
    } cmd_t;

    typedef struct {
        int            g;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          to;
        int            cyc;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [1:0]    req_valid;
    logic [1:0]    req_write;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]    req_ready;
    logic [1:0]    rsp_valid;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_resp;
    logic          rsp_timeout;
    logic [AW-1:0] AXI_AWADDR;
    logic          AXI_AWVALID;
    logic          AXI_AWREADY;
    logic [DW-1:0] AXI_WDATA;
    logic          AXI_WVALID;
    logic          AXI_WREADY;
    logic [1:0]    AXI_BRESP;
    logic          AXI_BVALID;
    logic          AXI_BREADY;
    logic [AW-1:0] AXI_ARADDR;
    logic          AXI_ARVALID;
    logic          AXI_ARREADY;
    logic [DW-1:0] AXI_RDATA;
    logic          AXI_RVALID;
    logic          AXI_RREADY;

    axil_rr_master #(
        .C_AXI_DATA_WIDTH(DW),
        .C_AXI_ADDR_WIDTH(AW),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .AXI_ACLK(clk), .AXI_ARESET(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout),
        .AXI_AWADDR(AXI_AWADDR), .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
        .AXI_WDATA(AXI_WDATA), .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
        .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
        .AXI_ARADDR(AXI_ARADDR), .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
        .AXI_RDATA(AXI_RDATA), .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    cmd_t slv_q[$];
    exp_t exp_q[$];
    cmd_t pend_cmd[2];
    bit   pend[2];
    int   model_last;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event not allowed here (cycle %0d)", name, cyc);
    endtask

    function automatic cmd_t mk(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                                input logic [DW-1:0] rd, input logic [1:0] br,
                                input int daw, input int dw, input int db, input int dar, input int dr);
        cmd_t c;
        c.wr = wr; c.addr = addr; c.wdata = wd; c.rdata = rd; c.bresp = br;
        c.d_aw = daw; c.d_w = dw; c.d_b = db; c.d_ar = dar; c.d_r = dr;
        return c;
    endfunction

    function automatic int rdelay();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 7));
        return int'($urandom_range(0, 1));
    endfunction

    function automatic cmd_t rand_cmd();
        return mk(1'($urandom_range(0, 1)), AW'($urandom), $urandom, $urandom, 2'($urandom),
                  rdelay(), rdelay(), rdelay(), rdelay(), rdelay());
    endfunction

    // Transaction-level expectation: response fields, stall-run timeout, completion cycle.
    function automatic exp_t model_rsp(input cmd_t c, input int g, input int acc);
        exp_t e;
        int lo, hi, r1, r2;
        e.g = g;
        if (c.wr) begin
            lo = (c.d_aw < c.d_w) ? c.d_aw : c.d_w;
            hi = (c.d_aw < c.d_w) ? c.d_w : c.d_aw;
            r1 = lo;
            r2 = (hi == lo) ? 0 : hi - lo - 1;
            e.data = '0;
            e.resp = c.bresp;
            e.to   = (r1 >= MAX_WAIT) || (r2 >= MAX_WAIT) || (c.d_b >= MAX_WAIT);
            e.cyc  = acc + 3 + hi + c.d_b;
        end else begin
            e.data = c.rdata;
            e.resp = 2'b00;
            e.to   = (c.d_ar >= MAX_WAIT) || (c.d_r >= MAX_WAIT);
            e.cyc  = acc + 3 + c.d_ar + c.d_r;
        end
        return e;
    endfunction

    function automatic int model_grant();
        if (pend[0] && pend[1]) return (model_last == 0) ? 1 : 0;
        return pend[1] ? 1 : 0;
    endfunction

    task automatic drive_reqs();
        req_valid = {pend[1], pend[0]};
        req_write = {pend_cmd[1].wr, pend_cmd[0].wr};
        req_addr  = {pend_cmd[1].addr, pend_cmd[0].addr};
        req_wdata = {pend_cmd[1].wdata, pend_cmd[0].wdata};
    endtask

    task automatic accept_one(output int g);
        int k;
        g = model_grant();
        drive_reqs();
        k = 0;
        @(negedge clk);
        while (req_ready == 2'b00 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (req_ready == 2'b00) begin
            $display("FAIL accept_timeout: req_ready never rose (cycle %0d)", cyc);
            n_fail++;
            $fatal(1, "no accept");
        end
        check("grant", req_ready, 2'b01 << g);
        slv_q.push_back(pend_cmd[g]);
        exp_q.push_back(model_rsp(pend_cmd[g], g, cyc));
        model_last = g;
        @(posedge clk);
        #1;
    endtask

    task automatic serve(input int refills);
        int g;
        int left;
        left = refills;
        while (pend[0] || pend[1]) begin
            accept_one(g);
            if (left > 0) begin
                pend_cmd[g] = rand_cmd();
                left--;
            end else begin
                pend[g] = 1'b0;
            end
            drive_reqs();
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d responses still outstanding, required 0", exp_q.size());
            n_fail++;
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input int who, input cmd_t c);
        pend[who] = 1'b1;
        pend_cmd[who] = c;
        serve(0);
        drain();
    endtask

    // Scoreboard monitor
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid != 2'b00) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_rsp_valid");
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_valid", rsp_valid, 2'b01 << e.g);
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_resp", rsp_resp, e.resp);
                    check("rsp_timeout", rsp_timeout, e.to);
                    check("rsp_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Scripted-delay slave plus master-side protocol checker
    initial begin : slave
        bit   s_act, aw_done, w_done, ar_done;
        int   aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        cmd_t s_c;
        logic p_awv, p_wv, p_arv, p_bready, p_rready;
        logic [AW-1:0] p_awaddr, p_araddr;
        logic [DW-1:0] p_wdata;
        AXI_AWREADY = 1'b0; AXI_WREADY = 1'b0; AXI_ARREADY = 1'b0;
        AXI_BVALID = 1'b0; AXI_RVALID = 1'b0; AXI_BRESP = 2'b00; AXI_RDATA = '0;
        s_act = 0; aw_done = 0; w_done = 0; ar_done = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        p_awv = 0; p_wv = 0; p_arv = 0; p_bready = 0; p_rready = 0;
        p_awaddr = '0; p_araddr = '0; p_wdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                s_act = 0; aw_done = 0; w_done = 0; ar_done = 0;
                AXI_AWREADY = 1'b0; AXI_WREADY = 1'b0; AXI_ARREADY = 1'b0;
                AXI_BVALID = 1'b0; AXI_RVALID = 1'b0;
                p_awv = 0; p_wv = 0; p_arv = 0; p_bready = 0; p_rready = 0;
            end else begin
                if (p_awv && AXI_AWREADY) aw_done = 1;
                if (p_wv && AXI_WREADY) w_done = 1;
                if (p_arv && AXI_ARREADY) ar_done = 1;
                if ((AXI_BVALID && p_bready) || (AXI_RVALID && p_rready)) begin
                    s_act = 0; aw_done = 0; w_done = 0; ar_done = 0;
                end
                if (p_awv && !AXI_AWREADY) begin
                    check("awvalid_hold", AXI_AWVALID, 1);
                    check("awaddr_stable", AXI_AWADDR, p_awaddr);
                end
                if (p_wv && !AXI_WREADY) begin
                    check("wvalid_hold", AXI_WVALID, 1);
                    check("wdata_stable", AXI_WDATA, p_wdata);
                end
                if (p_arv && !AXI_ARREADY) begin
                    check("arvalid_hold", AXI_ARVALID, 1);
                    check("araddr_stable", AXI_ARADDR, p_araddr);
                end
                if (s_act && aw_done) check("awvalid_drop", AXI_AWVALID, 0);
                if (s_act && w_done)  check("wvalid_drop", AXI_WVALID, 0);
                if (s_act && ar_done) check("arvalid_drop", AXI_ARVALID, 0);
                if (AXI_BREADY) check("bready_after_aw_w", s_act && aw_done && w_done, 1);
                if (AXI_RREADY) check("rready_after_ar", s_act && ar_done, 1);
                if (!s_act && (AXI_AWVALID || AXI_WVALID || AXI_ARVALID)) begin
                    if (slv_q.size() == 0) begin
                        fail_now("unexpected_axi_request");
                    end else begin
                        s_c = slv_q.pop_front();
                        s_act = 1;
                        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                        check("valids_on_entry", {AXI_AWVALID, AXI_WVALID, AXI_ARVALID},
                              s_c.wr ? 3'b110 : 3'b001);
                        if (s_c.wr) begin
                            check("awaddr", AXI_AWADDR, s_c.addr);
                            check("wdata", AXI_WDATA, s_c.wdata);
                        end else begin
                            check("araddr", AXI_ARADDR, s_c.addr);
                        end
                    end
                end
                AXI_AWREADY = 1'b0; AXI_WREADY = 1'b0; AXI_ARREADY = 1'b0;
                AXI_BVALID = 1'b0; AXI_RVALID = 1'b0;
                if (s_act) begin
                    if (AXI_AWVALID) begin AXI_AWREADY = (aw_cnt == s_c.d_aw); aw_cnt++; end
                    if (AXI_WVALID)  begin AXI_WREADY  = (w_cnt == s_c.d_w);   w_cnt++;  end
                    if (AXI_ARVALID) begin AXI_ARREADY = (ar_cnt == s_c.d_ar); ar_cnt++; end
                    if (s_c.wr && aw_done && w_done) begin
                        AXI_BVALID = (b_cnt >= s_c.d_b);
                        AXI_BRESP  = s_c.bresp;
                        b_cnt++;
                    end
                    if (!s_c.wr && ar_done) begin
                        AXI_RVALID = (r_cnt >= s_c.d_r);
                        AXI_RDATA  = s_c.rdata;
                        r_cnt++;
                    end
                end
                p_awv = AXI_AWVALID; p_wv = AXI_WVALID; p_arv = AXI_ARVALID;
                p_bready = AXI_BREADY; p_rready = AXI_RREADY;
                p_awaddr = AXI_AWADDR; p_wdata = AXI_WDATA; p_araddr = AXI_ARADDR;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_rsp_resp"}, rsp_resp, 0);
        check({tag, "_rsp_timeout"}, rsp_timeout, 0);
        check({tag, "_awvalid"}, AXI_AWVALID, 0);
        check({tag, "_wvalid"}, AXI_WVALID, 0);
        check({tag, "_arvalid"}, AXI_ARVALID, 0);
        check({tag, "_bready"}, AXI_BREADY, 0);
        check({tag, "_rready"}, AXI_RREADY, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int   g;
        exp_t e;
        rst = 1'b1;
        pend[0] = 0; pend[1] = 0;
        pend_cmd[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        pend_cmd[1] = pend_cmd[0];
        drive_reqs();
        repeat (3) @(posedge clk);
        #1;
        req_valid = 2'b11;
        @(negedge clk);
        check_reset_outputs("in_reset");
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_last = 1;
        @(negedge clk);
        check_reset_outputs("after_reset");
        @(posedge clk);
        #1;

        // Both requesters hold valid, zero-wait writes: grants alternate 0,1,0.
        pend[0] = 1; pend_cmd[0] = mk(1, 8'h20, 32'h11111111, 0, 2'b10, 0, 0, 0, 0, 0);
        pend[1] = 1; pend_cmd[1] = mk(1, 8'h24, 32'h22222222, 0, 2'b01, 0, 0, 0, 0, 0);
        accept_one(g);
        pend_cmd[g] = mk(1, 8'h28, 32'h33333333, 0, 2'b11, 0, 0, 0, 0, 0);
        drive_reqs();
        serve(0);
        drain();

        // Split write handshakes; then the read and timeout boundaries.
        run_one(0, mk(1, 8'h30, 32'hCAFEF00D, 0, 2'b00, 1, 3, 0, 0, 0));
        run_one(1, mk(0, 8'h10, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 2));
        run_one(0, mk(0, 8'h14, 0, 32'h0BADF00D, 0, 0, 0, 0, 1, 7));
        run_one(1, mk(0, 8'h18, 0, 32'h12345678, 0, 0, 0, 0, 0, 4));
        run_one(0, mk(0, 8'h1C, 0, 32'h87654321, 0, 0, 0, 0, 5, 0));
        run_one(1, mk(1, 8'h40, 32'hA5A5A5A5, 0, 2'b01, 0, 0, 5, 0, 0));
        run_one(0, mk(1, 8'h44, 32'h5A5A5A5A, 0, 2'b00, 0, 6, 0, 0, 0));
        run_one(1, mk(1, 8'h48, 32'h0F0F0F0F, 0, 2'b10, 4, 4, 4, 0, 0));

        for (int r = 0; r < 40; r++) begin
            int pat;
            pat = int'($urandom_range(1, 3));
            pend[0] = pat[0]; pend[1] = pat[1];
            pend_cmd[0] = rand_cmd();
            pend_cmd[1] = rand_cmd();
            serve(int'($urandom_range(0, 2)));
            if ($urandom_range(0, 1) == 1) drain();
        end
        drain();

        // Reset while waiting for the write response abandons the transaction.
        pend[0] = 1; pend_cmd[0] = mk(1, 8'h50, 32'h77777777, 0, 2'b01, 0, 0, 6, 0, 0);
        pend[1] = 0;
        accept_one(g);
        pend[0] = 0;
        drive_reqs();
        begin
            int k;
            k = 0;
            @(negedge clk);
            while (!AXI_BREADY && k < 50) begin
                @(negedge clk);
                k++;
            end
            check("bready_before_reset", AXI_BREADY, 1);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        e = exp_q.pop_back();
        pend[0] = 1; pend_cmd[0] = rand_cmd();
        pend[1] = 1; pend_cmd[1] = rand_cmd();
        drive_reqs();
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("mid_reset");
        check("abandoned_slave_queue", slv_q.size(), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_last = 1;
        accept_one(g);
        check("first_grant_after_reset", g, 0);
        pend[g] = 0;
        drive_reqs();
        serve(0);
        drain();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_rr_master.md
AXIL_RR_MASTER -- requirements
Module: axil_rr_master

Interface
REQ-001 SHALL have parameter C_AXI_DATA_WIDTH, default 32, AXI-Lite data width (DW).
REQ-002 SHALL have parameter C_AXI_ADDR_WIDTH, default 8, AXI-Lite address width (AW).
REQ-003 SHALL have parameter MAX_WAIT, default 5, cycle limit per waiting phase before timeout flag.
REQ-004 SHALL have one clock and a synchronous, active-high reset; clock and reset ports are listed below.
REQ-005 AXI_ACLK  in  1  sole clock, rising edge.
REQ-006 AXI_ARESET  in  1  synchronous reset, active-high.
REQ-007 req_valid  in  2  per-requester command valid; req_write  in  2  1=write, 0=read.
REQ-008 req_addr  in  2*AW  requester i at bits [i*AW +: AW]; req_wdata  in  2*DW  same packing.
REQ-009 req_ready  out  2  one-hot accept pulse.
REQ-010 rsp_valid  out  2  one-hot completion pulse; rsp_data  out  DW; rsp_resp  out  2; rsp_timeout  out  1.
REQ-011 AXI_AWADDR/AWVALID out, AXI_AWREADY in; AXI_WDATA/WVALID out, AXI_WREADY in; AXI_BRESP[1:0]/BVALID in, AXI_BREADY out.
REQ-012 AXI_ARADDR/ARVALID out, AXI_ARREADY in; AXI_RDATA/RVALID in, AXI_RREADY out.

Function
REQ-013 SHALL share one AXI-Lite master port between two requesters, one transaction outstanding at a time.
REQ-014 FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE.
REQ-015 IDLE: if any req_valid, grant round-robin (requester not granted last wins a tie), pulse req_ready[g] 1 cycle, latch addr/wdata/write, go to WR_REQ or RD_REQ.
REQ-016 WR_REQ: AWVALID and WVALID assert together on entry; each drops the cycle after its own handshake; exit to WR_RESP once both have handshaken (same or different cycles).
REQ-017 WR_RESP: BREADY=1; on BVALID capture BRESP, go to DONE.
REQ-018 RD_REQ: ARVALID=1 until ARREADY, then RD_DATA; RD_DATA: RREADY=1, on RVALID capture RDATA, go to DONE.
REQ-019 DONE: rsp_valid[g]=1 for exactly one cycle with rsp_data (reads; 0 for writes), rsp_resp (BRESP for writes; 2'b00 for reads), rsp_timeout; next state IDLE.
REQ-020 AXI valids SHALL never drop before their ready; AWADDR/WDATA/ARADDR stable while valid.
REQ-021 Wait counter: cleared on state entry and on any handshake; increments each cycle in WR_REQ/WR_RESP/RD_REQ/RD_DATA; reaching MAX_WAIT sets sticky rsp_timeout for the current transaction; counter saturates; transaction is NOT aborted.
REQ-022 Latency: accept at cycle N, AXI valid at N+1; with zero-wait slave write completes (rsp_valid) at N+3, read at N+3.
REQ-023 req_valid changes outside IDLE SHALL be ignored; next accept earliest the cycle after DONE.
REQ-024 Simultaneous AWREADY/WREADY SHALL be handled as both handshakes in one cycle.

Reset
REQ-025 Reset SHALL force IDLE, all AXI valids/readies 0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_resp=0, rsp_timeout=0, counter=0, last-grant=requester 1 (requester 0 wins first).
REQ-026 Reset mid-transaction SHALL abandon it; no rsp_valid is issued for it.

Verification
REQ-027 req_valid=2'b11 held, both writes, zero-wait slave -> grants alternate 0,1,0; each rsp_valid one-hot matches grant, rsp_resp=BRESP.
REQ-028 Write; AWREADY at +1, WREADY at +3 -> AWVALID drops after +1, WVALID held until +3, BREADY only after both.
REQ-029 Read addr 8'h10, slave RDATA=32'hDEADBEEF after 2 cycles -> rsp_data=32'hDEADBEEF, rsp_resp=2'b00, rsp_timeout=0.
REQ-030 Read, RVALID delayed 7 cycles, MAX_WAIT=5 -> rsp_timeout=1, RDATA still returned, ARVALID protocol intact.
REQ-031 Reset asserted during WR_RESP -> next cycle all outputs at reset values, no rsp_valid; next req_valid=2'b11 grants requester 0.
REQ-032 Attach AXI-Lite protocol checker to the master port for all scenarios -> zero assertion failures.
